// File: rtl/uart_pkg.sv
// Shared UART definitions: oversample ratio, character-format encodings and
// the frame-size / parity helpers used by both the transmitter and receiver.
package uart_pkg;

    localparam int unsigned OVERSAMPLE_COUNT = 31;

    typedef enum logic [1:0] {
        FRAME_5 = 2'b00,
        FRAME_6 = 2'b01,
        FRAME_7 = 2'b10,
        FRAME_8 = 2'b11
    } frame_type_e;

    typedef enum logic [1:0] {
        PARITY_NONE  = 2'b00,
        PARITY_EVEN  = 2'b01,
        PARITY_ODD   = 2'b10,
        PARITY_NONE3 = 2'b11
    } parity_type_e;

    function automatic logic [3:0] frame_size(input frame_type_e ft);
        return 4'd5 + {2'b00, ft};
    endfunction

    function automatic logic parity_enabled(input parity_type_e pt);
        return (pt == PARITY_EVEN) || (pt == PARITY_ODD);
    endfunction

    // Bits above the character width are masked so they never influence parity.
    function automatic logic parity_bit(input logic [7:0] data, input parity_type_e pt,
                                        input logic [3:0] fsize);
        logic [7:0] masked;
        masked = data & ~(8'hFF << fsize);
        case (pt)
            PARITY_EVEN: return ^masked;
            PARITY_ODD:  return ~^masked;
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Oversample counter: counts clk_en ticks while run is high and strobes
// bit_end on the tick that completes one bit period (COUNT_MAX+1 ticks).
module uart_bit_timer #(
    parameter int unsigned COUNT_MAX = 31,
    parameter int unsigned CNT_W     = $clog2(COUNT_MAX + 1)
) (
    input  logic clk,
    input  logic arst_n,
    input  logic run,
    input  logic clk_en,
    output logic bit_end
);

    logic [CNT_W-1:0] ovsample_cnt_q, ovsample_cnt_d;
    logic             at_max;

    assign at_max  = (ovsample_cnt_q == CNT_W'(COUNT_MAX));
    assign bit_end = run && clk_en && at_max;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        ovsample_cnt_d = ovsample_cnt_q;
        if (!run) begin
            ovsample_cnt_d = '0;
        end else if (clk_en) begin
            ovsample_cnt_d = at_max ? '0 : ovsample_cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) ovsample_cnt_q <= '0;
        else         ovsample_cnt_q <= ovsample_cnt_d;
    end

endmodule

// File: rtl/uart_xmit.sv
// UART transmitter: start bit, 5-8 data bits LSB first, optional parity, 1-2 stop bits.
// Define UART_XMIT_BREAK_EN to add the break_req input and the BREAK line condition.
module uart_xmit #(
    parameter int unsigned OVERSAMPLE_COUNT = 31
) (
    input  logic       clk,
    input  logic       arst_n,
    input  logic       active,
    input  logic       send,
    input  logic [7:0] data,
    input  logic [1:0] frame_type,
    input  logic [1:0] parity_type,
    input  logic       stop_type,
`ifdef UART_XMIT_BREAK_EN
    input  logic       break_req,
`endif
    input  logic       xmit_clk_en,
    output logic       tx,
    output logic       ready,
    output logic       busy,
    output logic       done
);
    import uart_pkg::*;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP1,
        ST_STOP2
`ifdef UART_XMIT_BREAK_EN
        , ST_BREAK
`endif
    } state_e;

    state_e       state_q, state_d;
    logic         tx_q, tx_d;
    logic         done_q, done_d;
    logic [7:0]   shift_q, shift_d;
    logic [3:0]   bitcnt_q, bitcnt_d;
    frame_type_e  frame_q, frame_d;
    parity_type_e parity_q, parity_d;
    logic         stop2_q, stop2_d;
    logic         par_bit_q, par_bit_d;

    logic         bit_end, accept, stop_two, frame_done;
    logic [3:0]   fsize;

    uart_bit_timer #(.COUNT_MAX(OVERSAMPLE_COUNT)) u_bit_timer (
        .clk     (clk),
        .arst_n  (arst_n),
        .run     (state_q != ST_IDLE),
        .clk_en  (xmit_clk_en),
        .bit_end (bit_end)
    );

    assign fsize  = frame_size(frame_q);
    assign accept = send && ready;

`ifdef UART_XMIT_BREAK_EN
    logic       quiet_q, quiet_d;
    logic [3:0] frame_bits;
    logic       bits_done;

    // A break borrows STOP1 as its one-bit mark: single stop bit, no done pulse.
    assign frame_bits = 4'd1 + fsize + {3'b000, parity_enabled(parity_q)} + (stop2_q ? 4'd2 : 4'd1);
    assign bits_done  = (bitcnt_q >= frame_bits - 4'd1);
    assign stop_two   = stop2_q && !quiet_q;
    assign frame_done = !quiet_q;
    assign ready      = (state_q == ST_IDLE) && active && !break_req;
`else
    assign stop_two   = stop2_q;
    assign frame_done = 1'b1;
    assign ready      = (state_q == ST_IDLE) && active;
`endif

    always_comb begin
        state_d   = state_q;
        tx_d      = tx_q;
        done_d    = 1'b0;
        shift_d   = shift_q;
        bitcnt_d  = bitcnt_q;
        frame_d   = frame_q;
        parity_d  = parity_q;
        stop2_d   = stop2_q;
        par_bit_d = par_bit_q;
`ifdef UART_XMIT_BREAK_EN
        quiet_d   = quiet_q;
`endif
        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
`ifdef UART_XMIT_BREAK_EN
                quiet_d = 1'b0;
                if (break_req) begin
                    state_d  = ST_BREAK;
                    tx_d     = 1'b0;
                    bitcnt_d = '0;
                    frame_d  = frame_type_e'(frame_type);
                    parity_d = parity_type_e'(parity_type);
                    stop2_d  = stop_type;
                    quiet_d  = 1'b1;
                end else
`endif
                if (accept) begin
                    state_d   = ST_START;
                    tx_d      = 1'b0;
                    bitcnt_d  = '0;
                    shift_d   = data;
                    frame_d   = frame_type_e'(frame_type);
                    parity_d  = parity_type_e'(parity_type);
                    stop2_d   = stop_type;
                    par_bit_d = parity_bit(data, parity_type_e'(parity_type),
                                           frame_size(frame_type_e'(frame_type)));
                end
            end
            ST_START: if (bit_end) begin
                state_d  = ST_DATA;
                tx_d     = shift_q[0];
                bitcnt_d = 4'd1;
            end
            ST_DATA: if (bit_end) begin
                if (bitcnt_q == fsize) begin
                    if (parity_enabled(parity_q)) begin
                        state_d = ST_PARITY;
                        tx_d    = par_bit_q;
                    end else begin
                        state_d = ST_STOP1;
                        tx_d    = 1'b1;
                    end
                end else begin
                    shift_d  = {1'b0, shift_q[7:1]};
                    tx_d     = shift_q[1];
                    bitcnt_d = bitcnt_q + 4'd1;
                end
            end
            ST_PARITY: if (bit_end) begin
                state_d = ST_STOP1;
                tx_d    = 1'b1;
            end
            ST_STOP1: if (bit_end) begin
                if (stop_two) begin
                    state_d = ST_STOP2;
                end else begin
                    state_d = ST_IDLE;
                    done_d  = frame_done;
                end
            end
            ST_STOP2: if (bit_end) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
`ifdef UART_XMIT_BREAK_EN
            // Leave only on a bit boundary so the following mark is one full bit.
            ST_BREAK: if (bit_end) begin
                if (bits_done && !break_req) begin
                    state_d = ST_STOP1;
                    tx_d    = 1'b1;
                end else if (!bits_done) begin
                    bitcnt_d = bitcnt_q + 4'd1;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // NOTE: the shadow and shift registers are reset too, so nothing on the line is X after reset.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q   <= ST_IDLE;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
            shift_q   <= '0;
            bitcnt_q  <= '0;
            frame_q   <= FRAME_5;
            parity_q  <= PARITY_NONE;
            stop2_q   <= 1'b0;
            par_bit_q <= 1'b0;
`ifdef UART_XMIT_BREAK_EN
            quiet_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
            shift_q   <= shift_d;
            bitcnt_q  <= bitcnt_d;
            frame_q   <= frame_d;
            parity_q  <= parity_d;
            stop2_q   <= stop2_d;
            par_bit_q <= par_bit_d;
`ifdef UART_XMIT_BREAK_EN
            quiet_q   <= quiet_d;
`endif
        end
    end

    assign tx   = tx_q;
    assign done = done_q;
    assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_xmit.sv
// Directed bench for uart_xmit: hand-composed bit patterns checked at mid-bit,
// plus done timing, back-to-back sends, clock-enable pacing and reset abort.
module tb_uart_xmit;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] ft;
        logic [1:0] pt;
        logic       st;
    } cfg_t;

    logic       clk = 1'b0;
    logic       arst_n = 1'b0;
    logic       active = 1'b0;
    logic       send = 1'b0;
    logic [7:0] data = 8'h00;
    logic [1:0] frame_type = 2'b00;
    logic [1:0] parity_type = 2'b00;
    logic       stop_type = 1'b0;
    logic       xmit_clk_en = 1'b0;
    logic       tx, ready, busy, done;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int div     = 1;
    int div_cnt = 0;

    uart_xmit dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .active      (active),
        .send        (send),
        .data        (data),
        .frame_type  (frame_type),
        .parity_type (parity_type),
        .stop_type   (stop_type),
`ifdef UART_XMIT_BREAK_EN
        .break_req   (1'b0),
`endif
        .xmit_clk_en (xmit_clk_en),
        .tx          (tx),
        .ready       (ready),
        .busy        (busy),
        .done        (done)
    );

    initial forever #5 clk = ~clk;

    // Oversample tick: high one clk in every div clks.
    initial forever begin
        @(negedge clk);
        div_cnt     = (div_cnt + 1 >= div) ? 0 : div_cnt + 1;
        xmit_clk_en = (div_cnt == 0);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apply(input cfg_t c);
        data        = c.data;
        frame_type  = c.ft;
        parity_type = c.pt;
        stop_type   = c.st;
    endtask

    // Present a request and return just after the accepting edge.
    task automatic start(input cfg_t c);
        @(negedge clk);
        apply(c);
        send = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Called just after the accept edge; returns just after the edge that raised done.
    task automatic run_frame(input string tag, input logic [11:0] exp_bits, input int nbits,
                             input int bitclks, input bit hold_send, input int change_at,
                             input cfg_t chg);
        int cyc, bi, busy_n, done_at, d;
        cyc = 0; bi = 0; busy_n = 0; done_at = -1; d = bitclks / 32;
        check({tag, "_busy_at_accept"}, busy, 1'b1);
        check({tag, "_ready_at_accept"}, ready, 1'b0);
        while (cyc <= nbits * bitclks + 8) begin
            if (cyc == 0 && !hold_send) send = 1'b0;
            if (cyc == change_at) apply(chg);
            if (busy === 1'b1) busy_n++;
            if (done === 1'b1) begin
                done_at = cyc;
                break;
            end
            if (bi < nbits && (cyc % bitclks) == bitclks / 2) begin
                check($sformatf("%s_bit%0d", tag, bi), tx, exp_bits[bi]);
                bi++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, "_bits_seen"}, bi, nbits);
        check({tag, "_done_time"}, (done_at > nbits * bitclks - d) && (done_at <= nbits * bitclks), 1'b1);
        check({tag, "_busy_clks"}, busy_n, done_at);
    endtask

    task automatic finish_idle(input string tag);
        @(posedge clk);
        #1;
        check({tag, "_done_one_clk"}, done, 1'b0);
        check({tag, "_tx_idle"}, tx, 1'b1);
        check({tag, "_busy_idle"}, busy, 1'b0);
    endtask

    cfg_t none_cfg;

    initial begin
        none_cfg = '0;
        arst_n = 1'b0;
        active = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", tx, 1'b1);
        check("rst_done", done, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", ready, 1'b1);
        @(negedge clk);
        arst_n = 1'b1;

        // 8N1 0xA5: 10 bits, done exactly 320 clks after accept
        start('{data: 8'hA5, ft: 2'b11, pt: 2'b00, st: 1'b0});
        run_frame("t1_8n1", {1'b1, 8'hA5, 1'b0}, 10, 32, 1'b0, -1, none_cfg);
        finish_idle("t1");

        // 7E2 0x83: 7 data bits 0000011 (two ones) -> parity 0; active drops mid-frame
        start('{data: 8'h83, ft: 2'b10, pt: 2'b01, st: 1'b1});
        active = 1'b0;
        run_frame("t2_7e2", {1'b1, 1'b1, 1'b0, 7'h03, 1'b0}, 11, 32, 1'b0, -1, none_cfg);
        check("t2_ready_inactive", ready, 1'b0);
        finish_idle("t2");

        // Request while inactive is not accepted
        @(negedge clk);
        send = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("inactive_no_accept", busy, 1'b0);
        check("inactive_tx", tx, 1'b1);
        @(negedge clk);
        send   = 1'b0;
        active = 1'b1;

        // 5O1 0x1F: five ones, odd parity bit 0
        start('{data: 8'h1F, ft: 2'b00, pt: 2'b10, st: 1'b0});
        run_frame("t3_5o1", {1'b1, 1'b0, 5'h1F, 1'b0}, 8, 32, 1'b0, -1, none_cfg);
        finish_idle("t3");

        // 6E1 0x07: 000111 has three ones, even parity bit 1
        start('{data: 8'h07, ft: 2'b01, pt: 2'b01, st: 1'b0});
        run_frame("t3b_6e1", {1'b1, 1'b1, 6'h07, 1'b0}, 9, 32, 1'b0, -1, none_cfg);
        finish_idle("t3b");

        // Back-to-back with send held: data changed to 0xAA during the first frame
        start('{data: 8'h55, ft: 2'b11, pt: 2'b00, st: 1'b0});
        run_frame("t4a_55", {1'b1, 8'h55, 1'b0}, 10, 32, 1'b1, 5,
                  '{data: 8'hAA, ft: 2'b11, pt: 2'b00, st: 1'b0});
        check("t4_ready_at_done", ready, 1'b1);
        @(posedge clk);
        #1;
        check("t4_done_one_clk", done, 1'b0);
        check("t4_gap_start_bit", tx, 1'b0);
        run_frame("t4b_aa", {1'b1, 8'hAA, 1'b0}, 10, 32, 1'b0, -1, none_cfg);
        finish_idle("t4");

        // Enable every 4th clk; config changed to 5O2 mid-frame must not matter
        @(negedge clk);
        div = 4;
        start('{data: 8'h3C, ft: 2'b11, pt: 2'b00, st: 1'b0});
        run_frame("t5_div4", {1'b1, 8'h3C, 1'b0}, 10, 128, 1'b0, 200,
                  '{data: 8'h00, ft: 2'b00, pt: 2'b10, st: 1'b1});
        finish_idle("t5");
        @(negedge clk);
        div = 1;

        // Reset in the middle of the data bits
        start('{data: 8'h00, ft: 2'b11, pt: 2'b00, st: 1'b0});
        send = 1'b0;
        repeat (100) @(posedge clk);
        #3;
        check("t6_tx_before_reset", tx, 1'b0);
        arst_n = 1'b0;
        #1;
        check("t6_tx_async", tx, 1'b1);
        check("t6_busy_async", busy, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("t6_no_done", done, 1'b0);
        @(negedge clk);
        arst_n = 1'b1;
        start('{data: 8'h5A, ft: 2'b11, pt: 2'b00, st: 1'b0});
        run_frame("t6_after", {1'b1, 8'h5A, 1'b0}, 10, 32, 1'b0, -1, none_cfg);
        finish_idle("t6");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
